mm_uart_sequencer: RTL and testbench
====================================

Name: mm_uart_sequencer

Overview:
- Top-level controller for the UART-fed matrix multiplier.
- Collects N*N bytes of matrix A, then N*N bytes of matrix B, from the receiver's frame output. Writes each byte into operand storage in row-major order.
- Starts the multiplier and waits for it to finish, then streams every result element back through the transmitter, high byte first.
- Sits between the receiver/transmitter (bclk domains) and the multiplier core (clk domain).

Parameters:
- N, 2, matrix dimension; matrices are N x N.
- DW, 8, operand element width; equals the UART data width.
- RW, 16, result element width; must be a multiple of 8, transmitted as RW/8 bytes.
- AW, 2, element address width; must satisfy 2**AW >= N*N.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_status  in  1  receiver busy level (bclk_x8 domain): high while a frame is being received.
- rx_frame  in  10  received frame: [0] start bit, [8:1] data LSB-first, [9] stop bit. Stable from the fall of rx_status until the next rise.
- a_we  out  1  one-cycle write strobe, matrix A storage.
- b_we  out  1  one-cycle write strobe, matrix B storage.
- wr_addr  out  AW  element index, row*N+col.
- wr_data  out  DW  element value.
- mm_start  out  1  one-cycle start pulse to the multiplier.
- mm_done  in  1  multiplier completion pulse or level (clk domain).
- rd_addr  out  AW  result element index.
- res_data  in  RW  result element at rd_addr; combinational read.
- tx_ready  out  1  transmit request level.
- tx_byte  out  8  byte to transmit; held stable while tx_ready is high.
- tx_status  in  1  transmitter busy level (bclk domain).
- frame_err  out  1  sticky framing-error flag.
- seq_state  out  3  current state encoding, for debug/LEDs.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = LOAD_A.
  - All counters, strobes, mm_start, tx_ready and frame_err = 0.
  - wr_addr, rd_addr, wr_data and tx_byte = 0.
  - Synchronizer flops are cleared to 0.
  - Reset mid-operation abandons everything; no partial state survives.
- Synchronizers:
  - rx_status and tx_status each pass through a 2-flop synchronizer, giving rx_s and tx_s.
  - A third flop on rx_s provides edge detection.
- Frame capture:
  - A falling edge of rx_s samples rx_frame directly; it is already stable by contract.
  - Frame valid when bit0=0 and bit9=1.
  - Valid frame in LOAD_A/LOAD_B: on the next cycle assert a_we or b_we for exactly 1 cycle, with wr_addr = element count and wr_data = rx_frame[8:1]. The count then increments.
  - Invalid frame: no write, count unchanged, frame_err set. frame_err clears only on reset.
  - Frames arriving in any other state are ignored; this is not an error.
- States (3-bit encoding in order):
  - LOAD_A(0): after the write of element N*N-1, clear the count and go to LOAD_B.
  - LOAD_B(1): after the write of element N*N-1, clear the count and go to START.
  - START(2): assert mm_start for 1 cycle, then go to WAIT_MM.
  - WAIT_MM(3): on mm_done=1, set rd_addr=0 and byte index=RW/8-1, then go to TX_LOAD.
  - TX_LOAD(4): tx_byte = res_data[8*idx+7 : 8*idx]; tx_ready=1; go to TX_ACK.
  - TX_ACK(5): hold tx_ready until tx_s=1, then drop tx_ready and go to TX_WAIT.
  - TX_WAIT(6): wait for tx_s=0, then step to the next byte:
    - If byte idx>0: idx-- and go to TX_LOAD.
    - Else if rd_addr<N*N-1: rd_addr++, idx=RW/8-1, and go to TX_LOAD.
    - Else go to LOAD_A.
  - Unused encoding 7: go to LOAD_A.
- Latency:
  - Falling edge of rx_status to write strobe: 3–4 clk.
  - Write of final B element to mm_start: 2 clk.
- mm_done asserted outside WAIT_MM is ignored.
- Address arithmetic is unsigned and never exceeds N*N-1; the count compare uses the full AW width.

Decomposition:
- Shared package/header:
  - State encodings.
  - Frame bit positions (START_BIT=0, STOP_BIT=9, DATA_LSB=1).
  - N, DW and RW defaults, for reuse by the multiplier and top.
- One natural sub-module: sync_edge_det (2-flop synchronizer plus rising/falling pulse outputs, async active-low reset). Instantiate it twice, for rx_status and tx_status.

Test Plan:
- Reset then 4 valid frames 0x01,0x02,0x03,0x04 -> a_we pulses at wr_addr 0..3 with those data values; seq_state 0 -> 1.
- Then 4 frames 0x05..0x08 -> b_we pulses at addr 0..3, then exactly one mm_start pulse 2 clk after the last b_we; seq_state = 3.
- Frame with stop bit 0 during LOAD_A -> no a_we, count unchanged, frame_err=1; next valid frame writes the same address; frame_err stays 1.
- In WAIT_MM, drive mm_done with res_data = 0x0013,0x0016,0x002B,0x0032 at rd_addr 0..3 -> tx_byte sequence 00,13,00,16,00,2B,00,32. Each tx_ready is held until tx_status rises. Afterwards the state returns to LOAD_A.
- Hold tx_status low for 50 clk after tx_ready rises -> tx_ready stays high and tx_byte stays stable throughout.
- Assert rst=0 mid-transmit (TX_WAIT) -> all outputs are immediately 0 and seq_state=0. A new 8-byte load then works normally.

Source files
------------

// File: rtl/mm_uart_sequencer_pkg.sv
// Shared definitions for the UART-fed matrix multiplier: sequencer states,
// frame bit layout and default datapath sizes.
package mm_uart_sequencer_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    START   = 3'd2,
    WAIT_MM = 3'd3,
    TX_LOAD = 3'd4,
    TX_ACK  = 3'd5,
    TX_WAIT = 3'd6
  } seq_state_t;

  localparam int START_BIT = 0;
  localparam int STOP_BIT  = 9;
  localparam int DATA_LSB  = 1;

  localparam int N_DEF  = 2;
  localparam int DW_DEF = 8;
  localparam int RW_DEF = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for a slow-domain level, with a third flop so the
// caller gets single-cycle rise/fall pulses in the clk domain.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_reg, s2_reg, s3_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign level = s2_reg;
  assign rise  = s2_reg & ~s3_reg;
  assign fall  = ~s2_reg & s3_reg;

endmodule

// File: rtl/mm_uart_sequencer.sv
// Loads matrices A and B from received UART frames, kicks the multiplier,
// then streams each result element back to the transmitter high byte first.
module mm_uart_sequencer
  import mm_uart_sequencer_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_status,
  input  logic [9:0]    rx_frame,
  output logic          a_we,
  output logic          b_we,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          mm_start,
  input  logic          mm_done,
  output logic [AW-1:0] rd_addr,
  input  logic [RW-1:0] res_data,
  output logic          tx_ready,
  output logic [7:0]    tx_byte,
  input  logic          tx_status,
  output logic          frame_err,
  output logic [2:0]    seq_state
);

  localparam int NB = RW / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [AW-1:0] LAST_ELEM = AW'(N * N - 1);
  localparam logic [IW-1:0] IDX_TOP   = IW'(NB - 1);

  logic rx_s, rx_rise, rx_fall;
  logic tx_s, tx_rise, tx_fall;

  sync_edge_det u_rx_sync (
    .clk(clk), .rst(rst), .din(rx_status),
    .level(rx_s), .rise(rx_rise), .fall(rx_fall)
  );

  sync_edge_det u_tx_sync (
    .clk(clk), .rst(rst), .din(tx_status),
    .level(tx_s), .rise(tx_rise), .fall(tx_fall)
  );

  logic unused_edges;
  assign unused_edges = rx_s ^ rx_rise ^ tx_rise ^ tx_fall;

  logic [7:0] res_bytes [NB];
  for (genvar gi = 0; gi < NB; gi++) begin : g_res_bytes
    assign res_bytes[gi] = res_data[8*gi +: 8];
  end

  seq_state_t    state_reg;
  logic [AW-1:0] count_reg;
  logic          load_done_reg;
  logic          pend_reg, pend_ok_reg;
  logic [DW-1:0] pend_data_reg;
  logic [IW-1:0] idx_reg;
  logic          a_we_reg, b_we_reg, mm_start_reg, tx_ready_reg, frame_err_reg;
  logic [AW-1:0] wr_addr_reg, rd_addr_reg;
  logic [DW-1:0] wr_data_reg;
  logic [7:0]    tx_byte_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= LOAD_A;
      count_reg     <= '0;
      load_done_reg <= 1'b0;
      pend_reg      <= 1'b0;
      pend_ok_reg   <= 1'b0;
      pend_data_reg <= '0;
      idx_reg       <= '0;
      a_we_reg      <= 1'b0;
      b_we_reg      <= 1'b0;
      mm_start_reg  <= 1'b0;
      tx_ready_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      wr_addr_reg   <= '0;
      rd_addr_reg   <= '0;
      wr_data_reg   <= '0;
      tx_byte_reg   <= '0;
    end else begin
      a_we_reg     <= 1'b0;
      b_we_reg     <= 1'b0;
      mm_start_reg <= 1'b0;

      // rx_frame is already stable when the synchronized busy level falls.
      pend_reg <= rx_fall;
      if (rx_fall) begin
        pend_ok_reg   <= !rx_frame[START_BIT] && rx_frame[STOP_BIT];
        pend_data_reg <= rx_frame[DATA_LSB +: DW];
      end

      case (state_reg)
        LOAD_A, LOAD_B: begin
          // Leave the load state one cycle after the final write strobe.
          if (load_done_reg) begin
            load_done_reg <= 1'b0;
            count_reg     <= '0;
            state_reg     <= (state_reg == LOAD_A) ? LOAD_B : START;
          end else if (pend_reg) begin
            if (pend_ok_reg) begin
              a_we_reg    <= (state_reg == LOAD_A);
              b_we_reg    <= (state_reg == LOAD_B);
              wr_addr_reg <= count_reg;
              wr_data_reg <= pend_data_reg;
              if (count_reg == LAST_ELEM) load_done_reg <= 1'b1;
              else                        count_reg     <= count_reg + AW'(1);
            end else begin
              frame_err_reg <= 1'b1;
            end
          end
        end
        START: begin
          mm_start_reg <= 1'b1;
          state_reg    <= WAIT_MM;
        end
        WAIT_MM: begin
          if (mm_done) begin
            rd_addr_reg <= '0;
            idx_reg     <= IDX_TOP;
            state_reg   <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          tx_byte_reg  <= res_bytes[idx_reg];
          tx_ready_reg <= 1'b1;
          state_reg    <= TX_ACK;
        end
        TX_ACK: begin
          if (tx_s) begin
            tx_ready_reg <= 1'b0;
            state_reg    <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (!tx_s) begin
            if (idx_reg != '0) begin
              idx_reg   <= idx_reg - IW'(1);
              state_reg <= TX_LOAD;
            end else if (rd_addr_reg != LAST_ELEM) begin
              rd_addr_reg <= rd_addr_reg + AW'(1);
              idx_reg     <= IDX_TOP;
              state_reg   <= TX_LOAD;
            end else begin
              state_reg <= LOAD_A;
            end
          end
        end
        default: state_reg <= LOAD_A;
      endcase
    end
  end

  assign a_we      = a_we_reg;
  assign b_we      = b_we_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign mm_start  = mm_start_reg;
  assign rd_addr   = rd_addr_reg;
  assign tx_ready  = tx_ready_reg;
  assign tx_byte   = tx_byte_reg;
  assign frame_err = frame_err_reg;
  assign seq_state = state_reg;

endmodule

// File: tb/tb_mm_uart_sequencer.sv
// Scoreboard bench for mm_uart_sequencer: expected writes and transmit bytes
// are queued as stimulus is driven and popped when the DUT produces them.
module tb_mm_uart_sequencer;

  localparam int N = 2, DW = 8, RW = 16, AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_status = 1'b0;
  logic [9:0]    rx_frame = '0;
  logic          a_we, b_we, mm_start, tx_ready, frame_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          mm_done = 1'b0;
  logic [RW-1:0] res_data;
  logic [7:0]    tx_byte;
  logic          tx_status = 1'b0;
  logic [2:0]    seq_state;

  always #5 clk = ~clk;

  mm_uart_sequencer #(.N(N), .DW(DW), .RW(RW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rx_status(rx_status), .rx_frame(rx_frame),
    .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .mm_start(mm_start), .mm_done(mm_done), .rd_addr(rd_addr),
    .res_data(res_data), .tx_ready(tx_ready), .tx_byte(tx_byte),
    .tx_status(tx_status), .frame_err(frame_err), .seq_state(seq_state)
  );

  // Result memory the multiplier would present.
  logic [RW-1:0] res_mem [4];
  initial begin
    res_mem[0] = 16'h0013; res_mem[1] = 16'h0016;
    res_mem[2] = 16'h002B; res_mem[3] = 16'h0032;
  end
  assign res_data = res_mem[rd_addr];

  typedef struct packed {
    logic          is_b;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] tx_q[$];
  int total = 0, bad = 0;
  int cyc = 0, last_we_cyc = 0, mm_start_cyc = 0, mm_start_cnt = 0;
  logic tx_ready_d = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  // Output monitor: pops the scoreboards whenever the DUT emits something.
  always @(negedge clk) begin
    wr_t  exp_w;
    logic [7:0] exp_b;
    if (rst) begin
      if (a_we || b_we) begin
        last_we_cyc = cyc;
        total++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected a_we=%0b b_we=%0b addr=%0d data=%02h", a_we, b_we, wr_addr, wr_data);
        end else begin
          exp_w = wr_q.pop_front();
          if ((a_we && b_we) || ({b_we, wr_addr, wr_data} !== exp_w)) begin
            bad++;
            $display("FAIL wr_strobe got a=%0b b=%0b addr=%0d data=%02h expected b=%0b addr=%0d data=%02h",
                     a_we, b_we, wr_addr, wr_data, exp_w.is_b, exp_w.addr, exp_w.data);
          end else
            $display("write %s[%0d] = %02h", exp_w.is_b ? "B" : "A", exp_w.addr, exp_w.data);
        end
      end
      if (mm_start) begin
        mm_start_cnt++;
        mm_start_cyc = cyc;
      end
      if (tx_ready && !tx_ready_d) begin
        total++;
        if (tx_q.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected byte=%02h", tx_byte);
        end else begin
          exp_b = tx_q.pop_front();
          if (tx_byte !== exp_b) begin
            bad++;
            $display("FAIL tx_byte got=%02h expected=%02h", tx_byte, exp_b);
          end else
            $display("tx byte %02h", tx_byte);
        end
      end
    end
    tx_ready_d = tx_ready;
  end

  task automatic send_frame(input logic [7:0] d, input logic good, input logic expect_we);
    int lat;
    @(negedge clk);
    rx_frame  = {good, d, 1'b0};
    rx_status = 1'b1;
    repeat (6) @(negedge clk);
    rx_status = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if ((a_we || b_we) && lat < 0) lat = i;
    end
    total++;
    if (expect_we) begin
      if (lat < 3 || lat > 4) begin
        bad++;
        $display("FAIL wr_latency got=%0d expected=3..4", lat);
      end
    end else if (lat != -1) begin
      bad++;
      $display("FAIL no_write got_strobe_at=%0d expected=none", lat);
    end
  endtask

  task automatic load_matrix(input logic is_b, input logic [7:0] base);
    for (int k = 0; k < N*N; k++) begin
      wr_q.push_back({is_b, AW'(k), base + 8'(k)});
      send_frame(base + 8'(k), 1'b1, 1'b1);
    end
  endtask

  task automatic pulse_mm_done();
    @(negedge clk); mm_done = 1'b1;
    @(negedge clk); mm_done = 1'b0;
  endtask

  task automatic wait_tx_ready(input logic level, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_ready === level) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL tx_ready_wait got=%0b expected=%0b", tx_ready, level);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({a_we, b_we, wr_addr, wr_data, mm_start, rd_addr, tx_ready, tx_byte, frame_err, seq_state} !== '0) begin
      bad++;
      $display("FAIL %s outputs a=%0b b=%0b wa=%0d wd=%02h st=%0b ra=%0d rdy=%0b tb=%02h fe=%0b ss=%0d expected all 0",
               name, a_we, b_we, wr_addr, wr_data, mm_start, rd_addr, tx_ready, tx_byte, frame_err, seq_state);
    end else
      $display("%s: all outputs 0", name);
  endtask

  task automatic check_state(input string name, input logic [2:0] exp);
    total++;
    if (seq_state !== exp) begin
      bad++;
      $display("FAIL %s seq_state got=%0d expected=%0d", name, seq_state, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_state("after_reset", 3'd0);
  endtask

  task automatic test_load_a();
    wr_q.push_back({1'b0, AW'(0), 8'h01});
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hEE, 1'b0, 1'b0);
    total++;
    if (frame_err !== 1'b1) begin
      bad++;
      $display("FAIL frame_err_set got=%0b expected=1", frame_err);
    end
    for (int k = 1; k < 4; k++) begin
      wr_q.push_back({1'b0, AW'(k), 8'(k + 1)});
      send_frame(8'(k + 1), 1'b1, 1'b1);
    end
    total++;
    if (frame_err !== 1'b1) begin
      bad++;
      $display("FAIL frame_err_sticky got=%0b expected=1", frame_err);
    end
    check_state("load_a_done", 3'd1);
  endtask

  task automatic test_load_b_start();
    mm_start_cnt = 0;
    load_matrix(1'b1, 8'h05);
    repeat (3) @(negedge clk);
    total++;
    if (mm_start_cnt != 1 || (mm_start_cyc - last_we_cyc) != 2) begin
      bad++;
      $display("FAIL mm_start pulses=%0d delay=%0d expected pulses=1 delay=2",
               mm_start_cnt, mm_start_cyc - last_we_cyc);
    end
    check_state("wait_mm", 3'd3);
    total++;
    if (wr_q.size() != 0) begin
      bad++;
      $display("FAIL wr_pending got=%0d expected=0", wr_q.size());
    end
  endtask

  task automatic test_transmit();
    logic [7:0] exp_bytes [8];
    logic ok;
    exp_bytes = '{8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};
    for (int b = 0; b < 8; b++) tx_q.push_back(exp_bytes[b]);
    pulse_mm_done();
    for (int b = 0; b < 8; b++) begin
      wait_tx_ready(1'b1, ok);
      if (b == 0) begin
        // Stall the transmitter: the request and byte must hold.
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          total++;
          if (tx_ready !== 1'b1 || tx_byte !== exp_bytes[0]) begin
            bad++;
            $display("FAIL tx_hold cycle=%0d ready=%0b byte=%02h expected ready=1 byte=%02h",
                     i, tx_ready, tx_byte, exp_bytes[0]);
          end
        end
      end
      tx_status = 1'b1;
      wait_tx_ready(1'b0, ok);
      repeat (2) @(negedge clk);
      tx_status = 1'b0;
    end
    repeat (6) @(negedge clk);
    check_state("tx_done", 3'd0);
    total++;
    if (tx_q.size() != 0) begin
      bad++;
      $display("FAIL tx_pending got=%0d expected=0", tx_q.size());
    end
  endtask

  task automatic test_reset_mid_tx();
    logic ok;
    load_matrix(1'b0, 8'h21);
    load_matrix(1'b1, 8'h31);
    repeat (3) @(negedge clk);
    tx_q.push_back(8'h00);
    pulse_mm_done();
    wait_tx_ready(1'b1, ok);
    tx_status = 1'b1;
    wait_tx_ready(1'b0, ok);
    check_state("in_tx_wait", 3'd6);
    #2 rst = 1'b0;
    #1 check_all_zero("mid_tx_reset");
    tx_status = 1'b0;
    wr_q.delete();
    tx_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reload();
    pulse_mm_done();
    repeat (3) @(negedge clk);
    check_state("mm_done_ignored", 3'd0);
    mm_start_cnt = 0;
    load_matrix(1'b0, 8'h41);
    check_state("reload_a", 3'd1);
    load_matrix(1'b1, 8'h51);
    repeat (3) @(negedge clk);
    total++;
    if (mm_start_cnt != 1 || (mm_start_cyc - last_we_cyc) != 2) begin
      bad++;
      $display("FAIL reload_mm_start pulses=%0d delay=%0d expected pulses=1 delay=2",
               mm_start_cnt, mm_start_cyc - last_we_cyc);
    end
    check_state("reload_wait_mm", 3'd3);
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reload_frame_err got=%0b expected=0", frame_err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_a();
    test_load_b_start();
    test_transmit();
    test_reset_mid_tx();
    test_reload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
